// File: rtl/u_xmit.sv
// UART transmitter: start bit, WORD_LEN data bits LSB-first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity cell after the MSB.
module u_xmit #(
  parameter int unsigned WORD_LEN  = 8,
  parameter int unsigned BIT_TICKS = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst_l,
  input  logic                EN_clk,
  input  logic                xmitH,
  input  logic [WORD_LEN-1:0] xmit_dataH,
  output logic                uart_xmitH,
  output logic                xmit_busyH,
  output logic                xmit_doneH
);

  localparam int unsigned BCW       = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [3:0]  CELL_LAST = 4'(BIT_TICKS - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WORD_LEN - 1);

  typedef enum logic [2:0] {
    t_IDLE   = 3'd0,
    t_START  = 3'd1,
    t_DATA   = 3'd2,
    t_PARITY = 3'd3,
    t_STOP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cell_q, cell_d;
  logic [BCW-1:0]      bit_q, bit_d;
  logic [WORD_LEN-1:0] shreg_q, shreg_d;
  logic                line_q, line_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cell_end;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  assign cell_end = EN_clk && (cell_q == CELL_LAST);

  always_comb begin
    state_d  = state_q;
    cell_d   = cell_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    if (state_q != t_IDLE && EN_clk) begin
      cell_d = (cell_q == CELL_LAST) ? '0 : cell_q + 4'd1;
    end

    case (state_q)
      t_IDLE: begin
        if (xmitH) begin
          shreg_d  = xmit_dataH;
          cell_d   = '0;
          bit_d    = '0;
          state_d  = t_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^xmit_dataH;
`endif
        end
      end
      t_START: begin
        if (cell_end) state_d = t_DATA;
      end
      t_DATA: begin
        if (cell_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = t_PARITY;
`else
            state_d = t_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      t_PARITY: begin
        if (cell_end) state_d = t_STOP;
      end
      t_STOP: begin
        if (cell_end) begin
          state_d = t_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = t_IDLE;
    endcase

    busy_d = (state_d != t_IDLE);

    // Line is registered from the next state so it moves exactly at cell boundaries.
    case (state_d)
      t_START:  line_d = 1'b0;
      t_DATA:   line_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      t_PARITY: line_d = parity_q;
`endif
      default:  line_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state_q  <= t_IDLE;
      cell_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      line_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cell_q   <= cell_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      line_q   <= line_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign uart_xmitH = line_q;
  assign xmit_busyH = busy_q;
  assign xmit_doneH = done_q;

endmodule

// File: tb/tb_u_xmit.sv
// Self-checking bench for u_xmit: frame-level reference model driven by directed and random stimulus.
module tb_u_xmit;

  localparam int BT = 16;
  localparam int WL = 8;

  logic          sys_clk;
  logic          sys_rst_l;
  logic          EN_clk;
  logic          xmitH;
  logic [WL-1:0] xmit_dataH;
  logic          uart_xmitH;
  logic          xmit_busyH;
  logic          xmit_doneH;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: the frame as a list of cells, position measured in EN ticks since accept.
  bit m_cells[0:15];
  int m_total  = 0;
  int m_n      = 0;
  bit m_active = 0;
  int m_frames = 0;

  u_xmit #(.WORD_LEN(WL), .BIT_TICKS(BT)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_l  (sys_rst_l),
    .EN_clk     (EN_clk),
    .xmitH      (xmitH),
    .xmit_dataH (xmit_dataH),
    .uart_xmitH (uart_xmitH),
    .xmit_busyH (xmit_busyH),
    .xmit_doneH (xmit_doneH)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic build_frame(input logic [WL-1:0] d);
    m_total = WL + 2;
`ifdef UART_TX_PARITY_EN
    m_total = WL + 3;
    m_cells[WL+1] = ^d;
`endif
    m_cells[0] = 1'b0;
    for (int i = 0; i < WL; i++) m_cells[1+i] = d[i];
    m_cells[m_total-1] = 1'b1;
  endtask

  function automatic logic gen_en(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 4) == 3;
      default: return logic'($urandom_range(0, 1));
    endcase
  endfunction

  // One sys_clk: drive inputs, clock, advance the model, compare outputs 1 time unit after the edge.
  task automatic cycle(input logic en, input logic x, input logic [WL-1:0] d);
    logic exp_done;
    logic exp_line;
    EN_clk = en;
    xmitH = x;
    xmit_dataH = d;
    @(posedge sys_clk);
    #1;
    cyc++;
    exp_done = 1'b0;
    if (!m_active && x) begin
      build_frame(d);
      m_active = 1;
      m_n = 0;
      m_frames++;
    end else if (m_active && en) begin
      m_n++;
      if (m_n == m_total * BT) begin
        m_active = 0;
        exp_done = 1'b1;
      end
    end
    exp_line = m_active ? m_cells[m_n / BT] : 1'b1;
    chk("line", uart_xmitH, exp_line);
    chk("busy", xmit_busyH, m_active);
    chk("done", xmit_doneH, exp_done);
  endtask

  // Accept d, then run to the end of the frame; noise scrambles data and pokes xmitH while busy.
  task automatic run_frame(input logic [WL-1:0] d, input int mode, input bit noise);
    int budget;
    cycle(gen_en(mode), 1'b1, d);
    chk("accept", xmit_busyH, 1'b1);
    budget = 0;
    while (m_active && budget < 20000) begin
      if (noise)
        cycle(gen_en(mode), ($urandom_range(0, 7) == 0), WL'($urandom));
      else
        cycle(gen_en(mode), 1'b0, d);
      budget++;
    end
    chk("frame_timeout", m_active, 1'b0);
    cycle(gen_en(mode), 1'b0, d);
  endtask

  initial begin
    sys_rst_l  = 1'b0;
    EN_clk     = 1'b0;
    xmitH      = 1'b0;
    xmit_dataH = '0;
    #12;
    chk("rst_line", uart_xmitH, 1'b1);
    chk("rst_busy", xmit_busyH, 1'b0);
    chk("rst_done", xmit_doneH, 1'b0);
    @(posedge sys_clk);
    #1;
    sys_rst_l = 1'b1;

    // Idle with EN running: nothing moves.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h00);

    // A5 at full rate, then 00 at quarter rate.
    run_frame(8'hA5, 0, 0);
    run_frame(8'h00, 1, 0);

    // xmitH held: 3C accepted, data switched to C3 while busy; C3 accepted in the done cycle.
    cycle(1'b1, 1'b1, 8'h3C);
    for (int i = 0; i < 20000 && m_frames < 4; i++) cycle(gen_en(0), 1'b1, 8'hC3);
    chk("b2b_second_accept", xmit_busyH, 1'b1);
    for (int i = 0; i < 20000 && m_active; i++) cycle(gen_en(0), 1'b0, 8'h00);
    chk("b2b_timeout", m_active, 1'b0);
    cycle(1'b1, 1'b0, 8'h00);

    // Reset during data bit 3 of FF.
    cycle(1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 200 && m_n < 4 * BT + 3; i++) cycle(1'b1, 1'b0, 8'hFF);
    #2;
    sys_rst_l = 1'b0;
    #1;
    chk("midrst_line", uart_xmitH, 1'b1);
    chk("midrst_busy", xmit_busyH, 1'b0);
    chk("midrst_done", xmit_doneH, 1'b0);
    m_active = 0;
    @(posedge sys_clk);
    #1;
    chk("inrst_line", uart_xmitH, 1'b1);
    sys_rst_l = 1'b1;
    cycle(1'b1, 1'b0, 8'h00);
    run_frame(8'hFF, 0, 0);

`ifdef UART_TX_PARITY_EN
    run_frame(8'h07, 0, 0);
    run_frame(8'h03, 0, 0);
`endif

    // Random bytes, random EN, noise on data/xmitH while busy.
    for (int k = 0; k < 6; k++) run_frame(WL'($urandom), int'($urandom_range(0, 2)), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
